// File: rtl/crc32_8023_chk.sv
// ---------------------------------------------------------------------------
// crc32_8023_chk
//
// Receive-side IEEE 802.3 FCS checker. It takes a byte stream framed by
// sof/eof, where the last four bytes of each frame are the FCS sent LS byte
// first. It computes CRC-32 over every byte before the FCS and compares the
// result with the received FCS. It also checks the frame length against
// MIN_LEN/MAX_LEN and emits a one-cycle result pulse per frame.
//
// CRC: reflected CRC-32, polynomial 0x04C11DB7 (0xEDB88320 reflected),
// init 0xFFFFFFFF, final XOR 0xFFFFFFFF. Each byte is processed LSB first,
// one byte per cycle.
//
// Optional build macro: CRC32_CHK_STAT_EN adds the frame statistics counters
// (stat_good, stat_fcs_err, stat_len_err) and their clear input stat_clr.
//
// Parameters
//   MIN_LEN      minimum legal frame length in bytes, FCS included
//   MAX_LEN      maximum legal frame length in bytes, FCS included
//   LEN_W        width of the length counter and res_len
//
// Ports
//   clk          clock; all logic on the rising edge
//   reset_n      asynchronous active-low reset
//   d            received byte
//   d_valid      d is valid this cycle
//   sof          first byte of frame (qualified by d_valid)
//   eof          last byte of frame, the last FCS byte (qualified by d_valid)
//   res_valid    one-cycle pulse: the result fields are valid
//   res_fcs_ok   received FCS equals the computed CRC
//   res_len_err  length out of range, or length counter saturated
//   res_abort    frame was cut short by a new sof before its eof
//   res_len      bytes in frame, FCS included; saturates at all-ones
//   crc_calc     final computed CRC (FCS form) of the last frame
//   stat_clr     (stat build) synchronous clear of the counters
//   stat_good    (stat build) count of good frames
//   stat_fcs_err (stat build) count of non-aborted frames with a bad FCS
//   stat_len_err (stat build) count of frames with a length error
// ---------------------------------------------------------------------------
module crc32_8023_chk #(
  parameter int MIN_LEN = 64,
  parameter int MAX_LEN = 1522,
  parameter int LEN_W   = 16
) (
  input  logic             clk,
  input  logic             reset_n,
  input  logic [7:0]       d,
  input  logic             d_valid,
  input  logic             sof,
  input  logic             eof,
  output logic             res_valid,
  output logic             res_fcs_ok,
  output logic             res_len_err,
  output logic             res_abort,
  output logic [LEN_W-1:0] res_len,
  output logic [31:0]      crc_calc
`ifdef CRC32_CHK_STAT_EN
  ,
  input  logic             stat_clr,
  output logic [31:0]      stat_good,
  output logic [31:0]      stat_fcs_err,
  output logic [31:0]      stat_len_err
`endif
);

  // FSM encoding
  localparam logic [1:0] ST_IDLE = 2'd0;
  localparam logic [1:0] ST_RX   = 2'd1;
  localparam logic [1:0] ST_DONE = 2'd2;

  localparam logic [31:0]      CRC_INIT      = 32'hFFFF_FFFF;
  localparam logic [31:0]      CRC_POLY_REFL = 32'hEDB8_8320;
  localparam logic [LEN_W-1:0] MIN_L         = LEN_W'(MIN_LEN);
  localparam logic [LEN_W-1:0] MAX_L         = LEN_W'(MAX_LEN);
  localparam logic [LEN_W-1:0] LEN_SAT       = {LEN_W{1'b1}};
  localparam logic [LEN_W-1:0] LEN_ONE       = LEN_W'(1);

  // One byte through the reflected CRC-32, LSB first.
  function automatic logic [31:0] crc_byte(input logic [31:0] c_in, input logic [7:0] b);
    logic [31:0] c;
    c = c_in ^ {24'h0, b};
    for (int i = 0; i < 8; i++) begin
      c = c[0] ? ((c >> 1) ^ CRC_POLY_REFL) : (c >> 1);
    end
    return c;
  endfunction

  // Length error: out of range, or counter pinned at saturation.
  function automatic logic len_bad(input logic [LEN_W-1:0] l);
    return (l < MIN_L) || (l > MAX_L) || (l == LEN_SAT);
  endfunction

  // -------------------------------------------------------------------------
  // State
  // -------------------------------------------------------------------------
  logic [1:0]       state_reg,       state_next;
  logic [7:0]       dly_reg [0:3];   // dly_reg[0] is the newest byte
  logic [7:0]       dly_next [0:3];
  logic [2:0]       fill_reg,        fill_next;   // valid bytes in the delay line, 0..4
  logic [LEN_W-1:0] len_reg,         len_next;
  logic [31:0]      crc_reg,         crc_next;

  logic             res_valid_reg,   res_valid_next;
  logic             res_fcs_ok_reg,  res_fcs_ok_next;
  logic             res_len_err_reg, res_len_err_next;
  logic             res_abort_reg,   res_abort_next;
  logic [LEN_W-1:0] res_len_reg,     res_len_next;
  logic [31:0]      crc_calc_reg,    crc_calc_next;

  // -------------------------------------------------------------------------
  // Delay line shift: the incoming byte enters at [0], everything moves up.
  // The byte leaving [3] is the one fed to the CRC, so the FCS itself never
  // reaches the CRC register.
  // -------------------------------------------------------------------------
  logic [7:0] dly_shift [0:3];

  assign dly_shift[0] = d;

  for (genvar gi = 1; gi < 4; gi++) begin : g_dly_shift
    assign dly_shift[gi] = dly_reg[gi-1];
  end

  // A byte is pushed out only once the delay line is full. A full delay line
  // before this byte also means the frame will hold at least 5 bytes, which
  // is the minimum for an FCS comparison to make sense.
  logic             push_out;
  logic [31:0]      crc_after;
  logic [LEN_W-1:0] len_inc;
  logic [31:0]      fcs_rx;

  assign push_out  = (fill_reg == 3'd4);
  assign crc_after = push_out ? crc_byte(crc_reg, dly_reg[3]) : crc_reg;
  assign len_inc   = (len_reg == LEN_SAT) ? len_reg : len_reg + LEN_ONE;
  // After the eof byte is shifted in, the delay line holds the FCS with the
  // most significant byte newest.
  assign fcs_rx    = {d, dly_reg[0], dly_reg[1], dly_reg[2]};

  // -------------------------------------------------------------------------
  // Next-state logic
  // -------------------------------------------------------------------------
  logic start_frame;

  always_comb begin
    state_next       = state_reg;
    dly_next         = dly_reg;
    fill_next        = fill_reg;
    len_next         = len_reg;
    crc_next         = crc_reg;
    res_valid_next   = 1'b0;
    res_fcs_ok_next  = res_fcs_ok_reg;
    res_len_err_next = res_len_err_reg;
    res_abort_next   = res_abort_reg;
    res_len_next     = res_len_reg;
    crc_calc_next    = crc_calc_reg;
    start_frame      = 1'b0;

    case (state_reg)
      ST_RX: begin
        if (d_valid) begin
          if (sof) begin
            // New sof mid-frame: report the old frame as aborted and start
            // over with this byte. An eof on the same byte is not honoured.
            res_valid_next   = 1'b1;
            res_fcs_ok_next  = 1'b0;
            res_abort_next   = 1'b1;
            res_len_next     = len_reg;
            res_len_err_next = len_bad(len_reg);
            crc_calc_next    = ~crc_reg;
            start_frame      = 1'b1;
          end else begin
            dly_next  = dly_shift;
            fill_next = push_out ? fill_reg : fill_reg + 3'd1;
            len_next  = len_inc;
            crc_next  = crc_after;
            if (eof) begin
              res_valid_next   = 1'b1;
              res_fcs_ok_next  = push_out && ((~crc_after) == fcs_rx);
              res_abort_next   = 1'b0;
              res_len_next     = len_inc;
              res_len_err_next = len_bad(len_inc);
              crc_calc_next    = ~crc_after;
              state_next       = ST_DONE;
            end
          end
        end
      end

      default: begin
        // IDLE and DONE behave the same apart from DONE's result pulse,
        // which was already registered on the way in.
        state_next = ST_IDLE;
        if (d_valid && sof) begin
          start_frame = 1'b1;
          if (eof) begin
            // Single-byte frame: no FCS can be present.
            res_valid_next   = 1'b1;
            res_fcs_ok_next  = 1'b0;
            res_abort_next   = 1'b0;
            res_len_next     = LEN_ONE;
            res_len_err_next = len_bad(LEN_ONE);
            crc_calc_next    = ~CRC_INIT;
            state_next       = ST_DONE;
          end else begin
            state_next = ST_RX;
          end
        end
      end
    endcase

    if (start_frame) begin
      dly_next[0] = d;
      dly_next[1] = 8'h00;
      dly_next[2] = 8'h00;
      dly_next[3] = 8'h00;
      fill_next   = 3'd1;
      len_next    = LEN_ONE;
      crc_next    = CRC_INIT;
      if (state_reg == ST_RX) begin
        state_next = ST_RX;
      end
    end
  end

  // -------------------------------------------------------------------------
  // Registers
  // -------------------------------------------------------------------------
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_reg       <= ST_IDLE;
      for (int i = 0; i < 4; i++) begin
        dly_reg[i] <= 8'h00;
      end
      fill_reg        <= 3'd0;
      len_reg         <= '0;
      crc_reg         <= CRC_INIT;
      res_valid_reg   <= 1'b0;
      res_fcs_ok_reg  <= 1'b0;
      res_len_err_reg <= 1'b0;
      res_abort_reg   <= 1'b0;
      res_len_reg     <= '0;
      crc_calc_reg    <= 32'h0;
    end else begin
      state_reg       <= state_next;
      dly_reg         <= dly_next;
      fill_reg        <= fill_next;
      len_reg         <= len_next;
      crc_reg         <= crc_next;
      res_valid_reg   <= res_valid_next;
      res_fcs_ok_reg  <= res_fcs_ok_next;
      res_len_err_reg <= res_len_err_next;
      res_abort_reg   <= res_abort_next;
      res_len_reg     <= res_len_next;
      crc_calc_reg    <= crc_calc_next;
    end
  end

  assign res_valid   = res_valid_reg;
  assign res_fcs_ok  = res_fcs_ok_reg;
  assign res_len_err = res_len_err_reg;
  assign res_abort   = res_abort_reg;
  assign res_len     = res_len_reg;
  assign crc_calc    = crc_calc_reg;

`ifdef CRC32_CHK_STAT_EN
  // -------------------------------------------------------------------------
  // Statistics: updated on the same edge that registers the result, so the
  // counts already include a frame while its res_valid is high.
  // -------------------------------------------------------------------------
  logic [31:0] stat_good_reg, stat_fcs_err_reg, stat_len_err_reg;

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      stat_good_reg    <= 32'h0;
      stat_fcs_err_reg <= 32'h0;
      stat_len_err_reg <= 32'h0;
    end else if (stat_clr) begin
      stat_good_reg    <= 32'h0;
      stat_fcs_err_reg <= 32'h0;
      stat_len_err_reg <= 32'h0;
    end else if (res_valid_next) begin
      if (res_fcs_ok_next && !res_len_err_next && !res_abort_next) begin
        stat_good_reg <= stat_good_reg + 32'd1;
      end
      if (!res_fcs_ok_next && !res_abort_next) begin
        stat_fcs_err_reg <= stat_fcs_err_reg + 32'd1;
      end
      if (res_len_err_next) begin
        stat_len_err_reg <= stat_len_err_reg + 32'd1;
      end
    end
  end

  assign stat_good    = stat_good_reg;
  assign stat_fcs_err = stat_fcs_err_reg;
  assign stat_len_err = stat_len_err_reg;
`endif

endmodule

// File: tb/tb_crc32_8023_chk.sv
// ---------------------------------------------------------------------------
// tb_crc32_8023_chk
//
// Two checker instances share one input stream: dut_a with MIN_LEN=1 and
// dut_b with the default limits. Expected results are queued when the eof
// (or aborting sof) byte is driven and compared when res_valid appears,
// including the exact one-cycle latency.
// ---------------------------------------------------------------------------
module tb_crc32_8023_chk;

  localparam int LEN_W = 16;

  logic             clk = 1'b0;
  logic             reset_n;
  logic [7:0]       d;
  logic             d_valid;
  logic             sof;
  logic             eof;

  logic             res_valid_a, res_fcs_ok_a, res_len_err_a, res_abort_a;
  logic [LEN_W-1:0] res_len_a;
  logic [31:0]      crc_calc_a;
  logic             res_valid_b, res_fcs_ok_b, res_len_err_b, res_abort_b;
  logic [LEN_W-1:0] res_len_b;
  logic [31:0]      crc_calc_b;

`ifdef CRC32_CHK_STAT_EN
  logic        stat_clr = 1'b0;
  logic [31:0] stat_good_a, stat_fcs_err_a, stat_len_err_a;
  logic [31:0] stat_good_b, stat_fcs_err_b, stat_len_err_b;
`endif

  always #5 clk = ~clk;

  crc32_8023_chk #(.MIN_LEN(1), .MAX_LEN(1522), .LEN_W(LEN_W)) dut_a (
    .clk         (clk),
    .reset_n     (reset_n),
    .d           (d),
    .d_valid     (d_valid),
    .sof         (sof),
    .eof         (eof),
    .res_valid   (res_valid_a),
    .res_fcs_ok  (res_fcs_ok_a),
    .res_len_err (res_len_err_a),
    .res_abort   (res_abort_a),
    .res_len     (res_len_a),
    .crc_calc    (crc_calc_a)
`ifdef CRC32_CHK_STAT_EN
    ,
    .stat_clr    (stat_clr),
    .stat_good   (stat_good_a),
    .stat_fcs_err(stat_fcs_err_a),
    .stat_len_err(stat_len_err_a)
`endif
  );

  crc32_8023_chk #(.MIN_LEN(64), .MAX_LEN(1522), .LEN_W(LEN_W)) dut_b (
    .clk         (clk),
    .reset_n     (reset_n),
    .d           (d),
    .d_valid     (d_valid),
    .sof         (sof),
    .eof         (eof),
    .res_valid   (res_valid_b),
    .res_fcs_ok  (res_fcs_ok_b),
    .res_len_err (res_len_err_b),
    .res_abort   (res_abort_b),
    .res_len     (res_len_b),
    .crc_calc    (crc_calc_b)
`ifdef CRC32_CHK_STAT_EN
    ,
    .stat_clr    (stat_clr),
    .stat_good   (stat_good_b),
    .stat_fcs_err(stat_fcs_err_b),
    .stat_len_err(stat_len_err_b)
`endif
  );

  // -------------------------------------------------------------------------
  // Bookkeeping
  // -------------------------------------------------------------------------
  int n_vec = 0;
  int n_err = 0;
  int cyc   = 0;

  always @(posedge clk) cyc <= cyc + 1;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got 0x%08h, expected 0x%08h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  // -------------------------------------------------------------------------
  // Reference model
  // -------------------------------------------------------------------------
  function automatic logic [7:0] data_byte(input int kind, input int i);
    if (kind == 0) return 8'(8'h31 + i);      // "123456789..."
    if (kind == 1) return 8'(i * 37 + 11);
    return 8'h00;
  endfunction

  function automatic logic [31:0] crc_model(input int kind, input int n);
    logic [31:0] c;
    c = 32'hFFFF_FFFF;
    for (int i = 0; i < n; i++) begin
      c = c ^ {24'h0, data_byte(kind, i)};
      for (int b = 0; b < 8; b++) begin
        c = c[0] ? ((c >> 1) ^ 32'hEDB8_8320) : (c >> 1);
      end
    end
    return ~c;
  endfunction

  function automatic bit len_err_m(input int len, input int min_l, input int max_l);
    return (len < min_l) || (len > max_l) || (len == 65535);
  endfunction

  logic [7:0] fbuf [0:2047];
  int         flen;

  // kind 0/1: n data bytes followed by their FCS (fx XORed into the last
  // FCS byte); kind 2: n zero bytes, no FCS.
  task automatic build(input int kind, input int n, input logic [7:0] fx);
    logic [31:0] c;
    flen = 0;
    for (int i = 0; i < n; i++) begin
      fbuf[flen] = data_byte(kind, i);
      flen++;
    end
    if (kind != 2) begin
      c = crc_model(kind, n);
      for (int k = 0; k < 4; k++) begin
        fbuf[flen] = c[8*k +: 8];
        flen++;
      end
      fbuf[flen-1] = fbuf[flen-1] ^ fx;
    end
  endtask

  // -------------------------------------------------------------------------
  // Scoreboard
  // -------------------------------------------------------------------------
  typedef struct {
    int          len;
    bit          ok;
    bit          abort;
    bit          chk_crc;
    logic [31:0] crc;
    int          due;
  } exp_t;

  exp_t sb [$];
  exp_t mon_e;
  bit   have_last = 1'b0;
  exp_t last_e;

  always @(negedge clk) begin
    if (!reset_n) begin
      have_last = 1'b0;
    end else if (res_valid_a || res_valid_b) begin
      chk("res_valid_a_vs_b", {31'b0, res_valid_b}, {31'b0, res_valid_a});
      if (sb.size() == 0) begin
        chk("unexpected_res_valid", {31'b0, res_valid_a | res_valid_b}, 32'd0);
      end else begin
        mon_e = sb.pop_front();
        $display("result: cycle=%0d len=%0d fcs_ok=%0b len_err=%0b/%0b abort=%0b crc=0x%08h",
                 cyc, res_len_a, res_fcs_ok_a, res_len_err_a, res_len_err_b, res_abort_a, crc_calc_a);
        chk("latency",       cyc, mon_e.due);
        chk("res_len_a",     32'(res_len_a), mon_e.len);
        chk("res_len_b",     32'(res_len_b), mon_e.len);
        chk("res_fcs_ok_a",  {31'b0, res_fcs_ok_a}, {31'b0, mon_e.ok});
        chk("res_fcs_ok_b",  {31'b0, res_fcs_ok_b}, {31'b0, mon_e.ok});
        chk("res_abort_a",   {31'b0, res_abort_a}, {31'b0, mon_e.abort});
        chk("res_abort_b",   {31'b0, res_abort_b}, {31'b0, mon_e.abort});
        chk("res_len_err_a", {31'b0, res_len_err_a}, {31'b0, len_err_m(mon_e.len, 1, 1522)});
        chk("res_len_err_b", {31'b0, res_len_err_b}, {31'b0, len_err_m(mon_e.len, 64, 1522)});
        if (mon_e.chk_crc) begin
          chk("crc_calc_a", crc_calc_a, mon_e.crc);
          chk("crc_calc_b", crc_calc_b, mon_e.crc);
        end
        last_e    = mon_e;
        have_last = 1'b1;
      end
    end else if (have_last) begin
      // Result fields must hold between pulses.
      chk("hold_res_len", 32'(res_len_a), last_e.len);
      chk("hold_fcs_ok",  {31'b0, res_fcs_ok_a}, {31'b0, last_e.ok});
      if (last_e.chk_crc) chk("hold_crc_calc", crc_calc_a, last_e.crc);
    end
  end

  // -------------------------------------------------------------------------
  // Driver
  // -------------------------------------------------------------------------
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic idle(input int n);
    d_valid = 1'b0; sof = 1'b0; eof = 1'b0;
    for (int i = 0; i < n; i++) tick();
  endtask

  // Drive the first nsend bytes of fbuf. eof goes on byte flen-1 only.
  // abort_len > 0 means the sof byte cuts short a frame of that length.
  task automatic drive(input int nsend, input bit gaps, input int abort_len, input exp_t e);
    exp_t ea;
    for (int i = 0; i < nsend; i++) begin
      d = fbuf[i]; d_valid = 1'b1; sof = (i == 0); eof = (i == flen - 1);
      if (i == 0 && abort_len > 0) begin
        ea = '{len: abort_len, ok: 1'b0, abort: 1'b1, chk_crc: 1'b0, crc: 32'h0, due: cyc + 1};
        sb.push_back(ea);
      end
      if (i == flen - 1) begin
        e.due = cyc + 1;
        sb.push_back(e);
      end
      tick();
      if (gaps) begin
        // Framing flags without d_valid must be ignored.
        d = 8'h5A; d_valid = 1'b0; sof = 1'b1; eof = 1'b1;
        tick();
      end
    end
    d_valid = 1'b0; sof = 1'b0; eof = 1'b0;
  endtask

  // -------------------------------------------------------------------------
  // Vector table
  // -------------------------------------------------------------------------
  typedef struct {
    int          kind;
    int          n;
    logic [7:0]  fx;
    bit          gaps;
    int          exp_len;
    bit          exp_ok;
    bit          chk_crc;
    logic [31:0] exp_crc;
  } vec_t;

  localparam int NV = 12;
  vec_t vecs [NV];

  initial begin
    exp_t e;

    vecs[0]  = '{0,    9, 8'h00, 1'b0,   13, 1'b1, 1'b1, 32'hCBF43926};
    vecs[1]  = '{0,    9, 8'h01, 1'b0,   13, 1'b0, 1'b1, 32'hCBF43926};
    vecs[2]  = '{0,    9, 8'h00, 1'b1,   13, 1'b1, 1'b1, 32'hCBF43926};
    vecs[3]  = '{1,   56, 8'h00, 1'b0,   60, 1'b1, 1'b1, crc_model(1, 56)};
    vecs[4]  = '{1,   60, 8'h00, 1'b0,   64, 1'b1, 1'b1, crc_model(1, 60)};
    vecs[5]  = '{1,   59, 8'h00, 1'b0,   63, 1'b1, 1'b1, crc_model(1, 59)};
    vecs[6]  = '{1,    1, 8'h00, 1'b0,    5, 1'b1, 1'b1, crc_model(1, 1)};
    vecs[7]  = '{2,    4, 8'h00, 1'b0,    4, 1'b0, 1'b0, 32'h0};
    vecs[8]  = '{2,    1, 8'h00, 1'b0,    1, 1'b0, 1'b0, 32'h0};
    vecs[9]  = '{1,   40, 8'h80, 1'b0,   44, 1'b0, 1'b1, crc_model(1, 40)};
    vecs[10] = '{1, 1518, 8'h00, 1'b0, 1522, 1'b1, 1'b1, crc_model(1, 1518)};
    vecs[11] = '{1, 1519, 8'h00, 1'b0, 1523, 1'b1, 1'b1, crc_model(1, 1519)};

    // Reset state
    reset_n = 1'b0; d = 8'h00; d_valid = 1'b0; sof = 1'b0; eof = 1'b0;
    tick(); tick();
    chk("reset_res_valid",   {31'b0, res_valid_a},   32'd0);
    chk("reset_res_fcs_ok",  {31'b0, res_fcs_ok_a},  32'd0);
    chk("reset_res_len_err", {31'b0, res_len_err_a}, 32'd0);
    chk("reset_res_abort",   {31'b0, res_abort_a},   32'd0);
    chk("reset_res_len",     32'(res_len_a),         32'd0);
    chk("reset_crc_calc",    crc_calc_a,             32'd0);
    chk("reset_crc_calc_b",  crc_calc_b,             32'd0);
    reset_n = 1'b1;
    tick();

    // Stray bytes without sof in IDLE are ignored (no result expected).
    d = 8'h77; d_valid = 1'b1; eof = 1'b1; tick();
    idle(3);

    // Table-driven frames
    for (int i = 0; i < NV; i++) begin
      build(vecs[i].kind, vecs[i].n, vecs[i].fx);
      e = '{len: vecs[i].exp_len, ok: vecs[i].exp_ok, abort: 1'b0,
            chk_crc: vecs[i].chk_crc, crc: vecs[i].exp_crc, due: 0};
      drive(flen, vecs[i].gaps, 0, e);
      idle(3);
    end

    // Abort: 20 bytes, then a new sof starts a valid 64-byte frame.
    build(1, 60, 8'h00);
    e = '{len: 64, ok: 1'b1, abort: 1'b0, chk_crc: 1'b1, crc: crc_model(1, 60), due: 0};
    drive(20, 1'b0, 0, e);
    drive(flen, 1'b0, 20, e);
    idle(3);

    // Back-to-back: the second sof arrives in the DONE cycle.
    build(0, 9, 8'h00);
    e = '{len: 13, ok: 1'b1, abort: 1'b0, chk_crc: 1'b1, crc: 32'hCBF43926, due: 0};
    drive(flen, 1'b0, 0, e);
    build(1, 60, 8'h00);
    e = '{len: 64, ok: 1'b1, abort: 1'b0, chk_crc: 1'b1, crc: crc_model(1, 60), due: 0};
    drive(flen, 1'b0, 0, e);
    idle(3);

    // Reset mid-frame discards it; a fresh frame afterwards is good.
    build(1, 60, 8'h00);
    drive(30, 1'b0, 0, e);
    reset_n = 1'b0;
    tick(); tick();
    reset_n = 1'b1;
    tick();
    chk("post_reset_res_len",  32'(res_len_a), 32'd0);
    chk("post_reset_crc_calc", crc_calc_b,     32'd0);
    drive(flen, 1'b0, 0, e);
    idle(4);
`ifdef CRC32_CHK_STAT_EN
    chk("stat_good_b",    stat_good_b,    32'd1);
    chk("stat_fcs_err_b", stat_fcs_err_b, 32'd0);
    chk("stat_good_a",    stat_good_a,    32'd1);
`endif

    idle(3);
    chk("scoreboard_empty", sb.size(), 32'd0);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
